// File: rtl/mdu_seq_if.sv
// Purpose: EX-stage handshake bundle between the pipeline and the multiply/divide unit.
// Latency: none; plain wires.
// Backpressure: stall flows back to the pipeline; start/flush/operands flow forward.
interface mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  // Pipeline side issues the op and consumes stall/done/result.
  modport master (
    output start, flush, funct3, rs1_data, rs2_data,
    input  stall, done, result
  );

  // Unit side.
  modport slave (
    input  start, flush, funct3, rs1_data, rs2_data,
    output stall, done, result
  );
endinterface

// File: rtl/mdu_seq.sv
// Purpose: iterative RV32M multiply/divide unit with its own sequencing FSM.
// Latency: XLEN+1 cycles start-to-done; divide-by-zero and signed overflow finish in 1.
// Backpressure: stall held combinationally from accept through the last iteration; flush aborts.
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  mdu_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic              sign_a_q, sign_b_q;
  logic [XLEN-1:0]   mag_a_q, mag_b_q;
  // hi_q: multiply accumulator / divide partial remainder.
  // lo_q: multiplier shifting out / dividend shifting out, quotient shifting in.
  logic [XLEN-1:0]   hi_q, lo_q, result_q;

  logic              accept, finish, stall_c, done_c;
  logic              a_signed, b_signed, is_div, special;
  logic [XLEN-1:0]   abs_a, abs_b, special_res;

  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff, hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  // Decode signedness, magnitudes and the no-iteration corner cases from the live inputs.
  always_comb begin
    a_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    b_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                  (bus.funct3 == 3'b110);
    is_div      = bus.funct3[2];
    abs_a       = (a_signed && bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
    abs_b       = (b_signed && bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;
    special     = 1'b0;
    special_res = '0;
    if (is_div && (bus.rs2_data == '0)) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? bus.rs1_data : '1;
    end else if (is_div && !bus.funct3[0] && (bus.rs1_data == MIN_NEG) &&
                 (bus.rs2_data == '1)) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step for both datapaths, plus sign correction for the final cycle.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mag_b_q});
    div_diff  = div_shift[XLEN-1:0] - mag_b_q;
    if (op_q[2]) begin
      hi_n = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {hi_n, lo_n};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -lo_n : lo_n;
    rem_fix  = sign_a_q ? -hi_n : hi_n;
    case (op_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and pipeline-facing handshake.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    stall_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept  = 1'b1;
          stall_c = 1'b1;
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // The instruction that owns this result is still in EX, so start is ignored here.
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latching, iteration and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      op_q     <= bus.funct3;
      sign_a_q <= a_signed && bus.rs1_data[XLEN-1];
      sign_b_q <= b_signed && bus.rs2_data[XLEN-1];
      mag_a_q  <= abs_a;
      mag_b_q  <= abs_b;
      hi_q     <= '0;
      lo_q     <= is_div ? abs_a : abs_b;
      if (special) result_q <= special_res;
    end else if ((state_q == CALC) && !bus.flush) begin
      cnt_q <= cnt_q + CNT_W'(1);
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (finish) result_q <= final_res;
    end
  end

  assign bus.stall  = stall_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Iterative RV32M multiply/divide unit plus its sequencing controller, sitting in the EX stage beside the ALU.
- The decoder flags M-extension R-type instructions (instr[25] set); the pipeline asserts start with funct3 and both operands.
- The block stalls the pipeline while it iterates, then presents the result for exactly one cycle so the instruction can advance.
- It handles the RISC-V divide-by-zero and signed-overflow corner cases without iterating.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  M-extension op valid in EX (opcode R-type and instr[25]).
- flush  input  1  EX flush (branch/jump redirect); aborts any operation.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  XLEN  operand A.
- rs2_data  input  XLEN  operand B.
- stall  output  1  hold IF/ID/EX; combinational.
- done  output  1  result valid this cycle; 1-cycle pulse.
- result  output  XLEN  final result; held until the next accepted start.

Behaviour:
- Reset values: state=IDLE, counter=0, done=0, result=0, all internal registers 0. Reset mid-operation discards the operation.
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - DONE: result presented.
- IDLE:
  - Accept when start=1 and flush=0.
  - Latch funct3, the operand signs and the operand magnitudes.
    - Signed view of rs1 for MULH, MULHSU, DIV, REM; of rs2 for MULH, DIV, REM.
  - Clear the accumulator and set counter=0.
  - Special case, go straight to DONE next cycle:
    - Divide op with rs2=0: DIV/DIVU give all-ones; REM/REMU give rs1.
    - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - Otherwise go to CALC.
- CALC: one iteration per cycle; counter increments; go to DONE after the iteration where counter==XLEN-1, i.e. XLEN cycles in CALC.
  - Multiply: shift-add on the magnitudes giving a 2*XLEN unsigned product.
  - Divide: restoring division on the magnitudes, one quotient bit per cycle.
- Completion cycle (last CALC cycle, or the accept cycle for a special case):
  - Apply sign correction and register the final result.
  - Product is negated if the operand signs differ (signed views only).
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of rs1.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DONE: done=1 and result valid for exactly one cycle, then IDLE unconditionally.
  - start is ignored in DONE: the same instruction is still in EX.
  - A new op can be accepted the cycle after DONE.
- stall = (IDLE and start and not flush) or CALC. stall=0 in DONE so the instruction advances with the result.
- Latency:
  - Normal op: start accepted at cycle T, CALC during T+1..T+32, done at T+33; the pipeline sees 33 stall cycles.
  - Special case: done at T+1, 1 stall cycle.
- flush:
  - In CALC: return to IDLE next cycle, no done pulse, result unchanged, stall drops immediately (combinational).
  - In DONE: no effect; done still pulses.
  - In IDLE together with start: op is not accepted.
- Operand changes after acceptance have no effect: all operands are latched.
- Arithmetic is modulo 2^XLEN. The magnitude of 0x80000000 is 0x80000000, treated as unsigned.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> stall high 33 cycles, done at T+33, result=0xFFFFFFEB, then IDLE.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU rs1=0x1234, rs2=0 -> done at T+1, result=0xFFFFFFFF; REM rs1=0x1234, rs2=0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Start DIV, assert flush at T+10 -> stall low that cycle, IDLE next cycle, no done, result keeps its prior value. A new MUL 3×5 the cycle after -> 15 at +33.
- Assert rst at T+5 of a MUL -> stall, done and result all 0 immediately; start held through DONE -> exactly one done pulse, no restart.
